// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between a fetch stage and a memory (data)
// stage. One access is in flight at a time; an access takes LATENCY+2 cycles
// from grant to the next possible grant:
//   IDLE (grant, cycle T) -> WAIT (cnt 1..LATENCY) -> RESP (ack, T+LATENCY+1)
//
// Handshake: a requester raises *_req and holds addr/we/wdata stable until it
// sees its one-cycle *_ack. The arbiter samples the request fields only in
// the grant cycle. Dropping *_req before the ack (squash) suppresses the ack
// and discards the data; a squashed write has already reached memory.
//
// Arbitration: data beats fetch, except that fetch wins once MAX_STREAK data
// grants have been made back to back while fetch was waiting.
//
// Ports
//   clk, rst                         clock, async active-low reset
//   f_req, f_addr                    fetch read request
//   f_ack, f_rdata                   fetch completion pulse and data
//   d_req, d_we, d_addr, d_wdata     data request
//   d_ack, d_rdata                   data completion pulse and data (0 on write)
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             single-port memory side
//   stall_f, stall_d                 stage stalls for the hazard unit
//   busy                             access in flight (state != IDLE)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_d,
  output logic        busy
);

  localparam logic [2:0] LP_LAT    = 3'(LATENCY);
  localparam logic [3:0] LP_STREAK = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [3:0]  r_streak;
  logic        r_owner_d;   // 1: data stage owns the access, 0: fetch
  logic        r_we;        // owned access is a write
  logic [31:0] r_data;

  logic w_idle;
  logic w_grant_f;
  logic w_grant_d;
  logic w_resp;

  // Gating with rst keeps the combinational request paths at 0 while reset
  // is asserted, even if requesters keep their lines high.
  assign w_idle    = rst && (r_state == IDLE);
  assign w_grant_f = w_idle && f_req && (!d_req || (r_streak == LP_STREAK));
  assign w_grant_d = w_idle && d_req && !w_grant_f;
  assign w_resp    = (r_state == RESP);

  // Memory side: driven only in the grant cycle, zero otherwise.
  assign mem_en    = w_grant_f || w_grant_d;
  assign mem_we    = w_grant_d && d_we;
  assign mem_addr  = w_grant_f ? f_addr : (w_grant_d ? d_addr : 32'd0);
  assign mem_wdata = w_grant_d ? d_wdata : 32'd0;

  // The ack is qualified by the owner's live request so a squashed access
  // never completes.
  assign f_ack   = w_resp && !r_owner_d && f_req;
  assign d_ack   = w_resp &&  r_owner_d && d_req;
  assign f_rdata = f_ack ? r_data : 32'd0;
  assign d_rdata = d_ack ? r_data : 32'd0;

  assign stall_f = rst && f_req && !f_ack;
  assign stall_d = rst && d_req && !d_ack;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_streak  <= 4'd0;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_data    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_f || w_grant_d) begin
            r_state   <= WAIT;
            r_cnt     <= 3'd1;
            r_owner_d <= w_grant_d;
            r_we      <= w_grant_d && d_we;
          end
          // The streak only counts data wins taken while fetch is waiting.
          if (w_grant_f || !f_req) begin
            r_streak <= 4'd0;
          end else if (w_grant_d) begin
            r_streak <= r_streak + 4'd1;
          end
        end
        WAIT: begin
          if (r_cnt == LP_LAT) begin
            r_data  <= r_we ? 32'd0 : mem_rdata;
            r_cnt   <= 3'd0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int MS = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_ack, d_ack, mem_en, mem_we, stall_f, stall_d, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.LATENCY(L), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_d(stall_d), .busy(busy)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [96:0] exp_g_q[$];   // {cycle, we, addr, wdata}
  logic [63:0] exp_f_q[$];   // {cycle, rdata}
  logic [63:0] exp_d_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_missing(input string name, input logic [159:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected %h (cycle %0d)", name, exp, cyc);
  endtask

  function automatic logic [159:0] all_outs();
    return {25'b0, f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr,
            mem_wdata, stall_f, stall_d, busy};
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // ---------------------------------------------------------------- memory emulator
  logic [31:0] emu_mem[logic [31:0]];
  bit          rd_pending = 0;
  int          rd_cyc = 0;
  logic [31:0] rd_data = '0;

  initial forever begin
    @(negedge clk);
    if (rst && mem_en) begin
      if (mem_we) emu_mem[mem_addr] = mem_wdata;
      else begin
        rd_pending = 1;
        rd_cyc     = cyc + L;
        rd_data    = emu_mem.exists(mem_addr) ? emu_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_pending && cyc == rd_cyc) begin
        mem_rdata  = rd_data;
        rd_pending = 0;
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------- requesters
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    int          squash;   // drop req after this many cycles (0 = never)
  } job_t;

  job_t f_jobs[$];
  job_t d_jobs[$];
  bit   f_active = 0, d_active = 0;
  int   f_sq = 0, d_sq = 0;
  bit   f_ack_seen = 0, d_ack_seen = 0;
  bit   req_en = 0;

  task automatic push_f(input logic [31:0] a, input int dly, input int sq);
    f_jobs.push_back('{addr: a, we: 1'b0, wdata: 32'd0, delay: dly, squash: sq});
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input int dly, input int sq);
    d_jobs.push_back('{addr: a, we: we, wdata: wd, delay: dly, squash: sq});
  endtask

  initial forever begin
    @(negedge clk);
    f_ack_seen = f_ack;
    d_ack_seen = d_ack;
  end

  initial begin
    job_t j;
    forever begin
      @(posedge clk); #1;
      if (req_en) begin
        if (!rst) f_active = 0;
        else begin
          if (f_active) begin
            if (f_ack_seen) f_active = 0;
            else if (f_sq > 0) begin
              f_sq--;
              if (f_sq == 0) f_active = 0;
            end
          end
          if (!f_active && f_jobs.size() > 0) begin
            if (f_jobs[0].delay > 0) f_jobs[0].delay = f_jobs[0].delay - 1;
            else begin
              j = f_jobs.pop_front();
              f_active = 1;
              f_addr   = j.addr;
              f_sq     = j.squash;
            end
          end
        end
        if (!f_active) f_addr = $urandom;
        f_req = f_active;
      end
    end
  end

  initial begin
    job_t j;
    forever begin
      @(posedge clk); #1;
      if (req_en) begin
        if (!rst) d_active = 0;
        else begin
          if (d_active) begin
            if (d_ack_seen) d_active = 0;
            else if (d_sq > 0) begin
              d_sq--;
              if (d_sq == 0) d_active = 0;
            end
          end
          if (!d_active && d_jobs.size() > 0) begin
            if (d_jobs[0].delay > 0) d_jobs[0].delay = d_jobs[0].delay - 1;
            else begin
              j = d_jobs.pop_front();
              d_active = 1;
              d_addr   = j.addr;
              d_we     = j.we;
              d_wdata  = j.wdata;
              d_sq     = j.squash;
            end
          end
        end
        if (!d_active) begin
          d_addr  = $urandom;
          d_we    = 1'($urandom_range(0, 1));
          d_wdata = $urandom;
        end
        d_req = d_active;
      end
    end
  end

  // ---------------------------------------------------------------- reference model
  // Transaction view: one access at a time, ack LATENCY+1 cycles after grant,
  // data from a sparse memory image, data-first arbitration with a cap on how
  // many data wins fetch can be made to sit through.
  logic [31:0] model_mem[logic [31:0]];
  bit          pend = 0, pend_d = 0, m_f_ack = 0, m_d_ack = 0, m_busy = 0;
  int          resp_cyc = 0, streak = 0;
  logic [31:0] pend_data = '0;

  initial begin
    bit          fw;
    logic        gwe;
    logic [31:0] ga, gwd;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        pend = 0; streak = 0; m_f_ack = 0; m_d_ack = 0; m_busy = 0;
      end else begin
        m_f_ack = 0;
        m_d_ack = 0;
        m_busy  = pend;
        if (pend) begin
          if (cyc == resp_cyc) begin
            if (pend_d && d_req) begin
              m_d_ack = 1;
              exp_d_q.push_back({32'(cyc), pend_data});
            end
            if (!pend_d && f_req) begin
              m_f_ack = 1;
              exp_f_q.push_back({32'(cyc), pend_data});
            end
            pend = 0;
          end
        end else if (f_req || d_req) begin
          fw  = f_req && (!d_req || streak == MS);
          gwe = fw ? 1'b0 : d_we;
          ga  = fw ? f_addr : d_addr;
          gwd = fw ? 32'd0 : d_wdata;
          exp_g_q.push_back({32'(cyc), gwe, ga, gwd});
          if (gwe) begin
            model_mem[ga] = gwd;
            pend_data = 32'd0;
          end else begin
            pend_data = model_mem.exists(ga) ? model_mem[ga] : init_val(ga);
          end
          pend     = 1;
          pend_d   = !fw;
          resp_cyc = cyc + L + 1;
          if (fw || !f_req) streak = 0;
          else streak = streak + 1;
        end else begin
          streak = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  initial forever begin
    logic [96:0] eg;
    logic [63:0] ea;
    @(negedge clk);
    if (!rst) begin
      check("reset_outputs_zero", all_outs(), 160'd0);
    end else begin
      while (exp_g_q.size() > 0 && int'(exp_g_q[0][96:65]) < cyc)
        report_missing("grant_missing", 160'(exp_g_q.pop_front()));
      while (exp_f_q.size() > 0 && int'(exp_f_q[0][63:32]) < cyc)
        report_missing("f_ack_missing", 160'(exp_f_q.pop_front()));
      while (exp_d_q.size() > 0 && int'(exp_d_q[0][63:32]) < cyc)
        report_missing("d_ack_missing", 160'(exp_d_q.pop_front()));

      if (mem_en) begin
        if (exp_g_q.size() == 0) check("grant_unexpected", {32'(cyc), mem_we, mem_addr, mem_wdata}, 160'd0);
        else begin
          eg = exp_g_q.pop_front();
          check("grant", {32'(cyc), mem_we, mem_addr, mem_wdata}, 160'(eg));
        end
      end else begin
        check("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 160'd0);
      end

      if (f_ack) begin
        if (exp_f_q.size() == 0) check("f_ack_unexpected", {32'(cyc), f_rdata}, 160'd0);
        else begin
          ea = exp_f_q.pop_front();
          check("f_ack", {32'(cyc), f_rdata}, 160'(ea));
        end
      end else begin
        check("f_rdata_zero", f_rdata, 160'd0);
      end

      if (d_ack) begin
        if (exp_d_q.size() == 0) check("d_ack_unexpected", {32'(cyc), d_rdata}, 160'd0);
        else begin
          ea = exp_d_q.pop_front();
          check("d_ack", {32'(cyc), d_rdata}, 160'(ea));
        end
      end else begin
        check("d_rdata_zero", d_rdata, 160'd0);
      end

      check("stall_f", stall_f, 160'(f_req && !m_f_ack));
      check("stall_d", stall_d, 160'(d_req && !m_d_ack));
      check("busy", busy, 160'(m_busy));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((f_active || d_active || f_jobs.size() > 0 || d_jobs.size() > 0 || pend)
           && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check("idle_reached", 160'(n < max_cyc), 160'd1);
    if (n >= max_cyc) begin
      f_jobs.delete();
      d_jobs.delete();
      f_active = 0;
      d_active = 0;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    f_addr = 32'h1234; d_addr = 32'h5678; d_wdata = 32'hFFFF0000;
    model_mem[32'h10] = 32'h00500093;
    emu_mem[32'h10]   = 32'h00500093;

    // Reset with both requests high: everything must stay at 0.
    repeat (2) @(negedge clk);
    #1 check("reset_hold_outputs", all_outs(), 160'd0);

    // Fetch only; its request lands on the first cycle after release.
    push_f(32'h10, 0, 0);
    @(negedge clk); #1;
    f_req = 1'b0; d_req = 1'b0; rst = 1'b1; req_en = 1;
    wait_idle(40);

    // Simultaneous requests: data first, fetch right after.
    push_f(32'h14, 0, 0);
    push_d(32'h24, 1'b0, 32'h0, 0, 0);
    wait_idle(40);

    // Write, then a fetch of the same word reads it back.
    push_d(32'h20, 1'b1, 32'hDEADBEEF, 0, 0);
    push_f(32'h20, 4, 0);
    wait_idle(40);

    // Starvation cap: fetch gets grant 5 while data keeps asking.
    for (int i = 0; i < 6; i++) push_d(32'h100 + 32'(4 * i), 1'b0, 32'h0, 0, 0);
    push_f(32'h200, 0, 0);
    wait_idle(80);

    // Squash: fetch dropped after one cycle; data arrives in the RESP cycle.
    push_f(32'h30, 0, 1);
    push_d(32'h34, 1'b0, 32'h0, 3, 0);
    wait_idle(40);

    // Reset during cycle 2 of an in-flight fetch read.
    push_f(32'h40, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_en && n < 20);
    check("mid_reset_grant_seen", 160'(mem_en), 160'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("mid_reset_outputs", all_outs(), 160'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    wait_idle(40);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 80; i++) begin
      push_f(32'h400 + 32'(4 * $urandom_range(0, 7)), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
      push_d(32'h400 + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end
    wait_idle(4000);

    check("grant_queue_drained", 160'(exp_g_q.size()), 160'd0);
    check("f_ack_queue_drained", 160'(exp_f_q.size()), 160'd0);
    check("d_ack_queue_drained", 160'(exp_d_q.size()), 160'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
